// File: rtl/throttle_ramp_ctrl.sv
// Purpose: debounces two pedal inputs and turns them into a rate-limited 8-bit motor speed command.
// Latency: a pedal change is accepted after DEB_CYCLES edges; speed_cmd then moves one step per RAMP_DIV-cycle tick.
// Backpressure: none; cmd_valid is a one-cycle strobe and the consumer must capture speed_cmd when it sees it.
module throttle_ramp_ctrl #(
  parameter int DEB_CYCLES = 3,
  parameter int RAMP_DIV   = 1024,
  parameter int UP_STEP    = 4,
  parameter int DOWN_STEP  = 8,
  parameter int BRAKE_STEP = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] accel_in,
  input  logic [3:0] brake_in,
  input  logic       temp_fault,
  output logic [7:0] speed_cmd,
  output logic       cmd_valid,
  output logic [2:0] ramp_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCEL = 3'd1,
    HOLD  = 3'd2,
    DECEL = 3'd3,
    BRAKE = 3'd4
  } ramp_state_t;

  localparam logic [4:0]  DEB       = 5'(DEB_CYCLES);
  localparam logic [15:0] TICK_LAST = 16'(RAMP_DIV - 1);
  localparam logic [9:0]  UP10      = 10'(UP_STEP);
  localparam logic [9:0]  DN10      = 10'(DOWN_STEP);
  localparam logic [9:0]  BRK10     = 10'(BRAKE_STEP);

  // Index 0 is the accelerator pedal, index 1 the brake pedal.
  logic [3:0] raw  [2];
  logic [3:0] held [2];
  logic [3:0] cnt  [2];
  logic [3:0] filt [2];
  logic [4:0] run  [2];

  logic [3:0]  accel_f;
  logic [3:0]  brake_f;
  logic [3:0]  pedal_diff;
  logic [7:0]  target_full;
  logic [7:0]  target;
  logic [15:0] tick_cnt;
  logic        tick;
  logic [9:0]  up_sum;
  logic [9:0]  dn_step;
  logic [9:0]  dn_floor;
  logic [7:0]  dn_diff;
  logic [7:0]  speed_nxt;
  ramp_state_t st;

  // Count how many consecutive edges (including this one) have seen the current raw value.
  always_comb begin
    raw[0] = accel_in;
    raw[1] = brake_in;
    for (int i = 0; i < 2; i++) begin
      run[i] = 5'd1;
      if (raw[i] == held[i]) begin
        run[i] = {1'b0, cnt[i]} + 5'd2;
      end
    end
  end

  // Debouncers: reload on any raw change, accept the value once it has been stable long enough.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      for (int i = 0; i < 2; i++) begin
        held[i] <= 4'd0;
        cnt[i]  <= 4'd0;
        filt[i] <= 4'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (raw[i] != held[i]) begin
          held[i] <= raw[i];
          cnt[i]  <= 4'd0;
        end else if (cnt[i] != 4'hF) begin
          cnt[i] <= cnt[i] + 4'd1;
        end
        if (run[i] >= DEB) begin
          filt[i] <= raw[i];
        end
      end
    end
  end

  assign accel_f = filt[0];
  assign brake_f = filt[1];

  // Target speed: pedal difference scaled by 16 (max 240), halved while overheated.
  always_comb begin
    pedal_diff  = accel_f - brake_f;
    target_full = (accel_f > brake_f) ? {pedal_diff, 4'b0000} : 8'd0;
    target      = temp_fault ? {1'b0, target_full[7:1]} : target_full;
  end

  // Ramp tick divider; it restarts from zero whenever the system is disabled or reset.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      tick_cnt <= 16'd0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= 16'd0;
    end else begin
      tick_cnt <= tick_cnt + 16'd1;
    end
  end

  assign tick = en && (tick_cnt == TICK_LAST);

  // Next speed: one clamped step toward the target per tick; wide arithmetic avoids wrap.
  always_comb begin
    speed_nxt = speed_cmd;
    up_sum    = {2'b00, speed_cmd} + UP10;
    dn_step   = (brake_f != 4'd0) ? BRK10 : DN10;
    dn_floor  = {2'b00, target} + dn_step;
    dn_diff   = speed_cmd - dn_step[7:0];
    if (tick) begin
      if (speed_cmd < target) begin
        speed_nxt = (up_sum >= {2'b00, target}) ? target : up_sum[7:0];
      end else if (speed_cmd > target) begin
        speed_nxt = ({2'b00, speed_cmd} <= dn_floor) ? target : dn_diff;
      end
    end
  end

  // Output register; cmd_valid flags the first cycle a new speed value is visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      speed_cmd <= 8'd0;
      cmd_valid <= 1'b0;
    end else if (!en) begin
      speed_cmd <= 8'd0;
      cmd_valid <= (speed_cmd != 8'd0);
    end else begin
      speed_cmd <= speed_nxt;
      cmd_valid <= (speed_nxt != speed_cmd);
    end
  end

  // Ramp state is a pure decode of the current speed, target and brake level.
  always_comb begin
    st = IDLE;
    if (speed_cmd < target) begin
      st = ACCEL;
    end else if (speed_cmd > target) begin
      st = (brake_f != 4'd0) ? BRAKE : DECEL;
    end else if (target != 8'd0) begin
      st = HOLD;
    end
  end

  assign ramp_state = st;

endmodule

// File: tb/tb_throttle_ramp_ctrl.sv
// Bench for throttle_ramp_ctrl: table of pedal scenarios plus hand-written en/rst/glitch sequences.
// Expected speed steps are queued when stimulus is applied and consumed on each cmd_valid strobe.
// Ends with a single CHECKS/ERRORS summary line.
module tb_throttle_ramp_ctrl;

  localparam int UP  = 4;
  localparam int DN  = 8;
  localparam int BRK = 16;

  localparam int S_IDLE  = 0;
  localparam int S_ACCEL = 1;
  localparam int S_HOLD  = 2;
  localparam int S_DECEL = 3;
  localparam int S_BRAKE = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] accel_in;
  logic [3:0] brake_in;
  logic       temp_fault;
  logic [7:0] speed_cmd;
  logic       cmd_valid;
  logic [2:0] ramp_state;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  throttle_ramp_ctrl #(
    .DEB_CYCLES (3),
    .RAMP_DIV   (4),
    .UP_STEP    (4),
    .DOWN_STEP  (8),
    .BRAKE_STEP (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .accel_in   (accel_in),
    .brake_in   (brake_in),
    .temp_fault (temp_fault),
    .speed_cmd  (speed_cmd),
    .cmd_valid  (cmd_valid),
    .ramp_state (ramp_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       t;
    int         target;
    int         mid;
    int         mid_state;
    int         cycles;
    int         fin_state;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected speed values for a ramp from 'from' to 'to', one entry per tick.
  task automatic push_ramp(input int from, input int to, input bit brk);
    int cur;
    int step;
    cur = from;
    while (cur != to) begin
      if (cur < to) begin
        cur = (cur + UP > to) ? to : cur + UP;
      end else begin
        step = brk ? BRK : DN;
        cur = (cur - step < to) ? to : cur - step;
      end
      exp_q.push_back(cur);
    end
  endtask

  // Scoreboard: every cmd_valid strobe must match the next queued speed value.
  always @(posedge clk) begin
    int e;
    #1;
    if (cmd_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_cmd_valid", int'(cmd_valid), 0);
      end else begin
        e = exp_q.pop_front();
        chk("cmd_step", int'(speed_cmd), e);
      end
    end
  end

  initial begin
    int model_speed;
    int hit;

    tbl[0]  = '{4'd5,  4'd0,  1'b0, 80,  5, S_ACCEL, 100, S_HOLD};
    tbl[1]  = '{4'd5,  4'd15, 1'b0, 0,   5, S_BRAKE, 40,  S_IDLE};
    tbl[2]  = '{4'd15, 4'd0,  1'b1, 120, 5, S_ACCEL, 140, S_HOLD};
    tbl[3]  = '{4'd15, 4'd0,  1'b0, 240, 2, S_ACCEL, 140, S_HOLD};
    tbl[4]  = '{4'd10, 4'd0,  1'b0, 160, 5, S_DECEL, 60,  S_HOLD};
    tbl[5]  = '{4'd10, 4'd3,  1'b0, 112, 5, S_BRAKE, 30,  S_HOLD};
    tbl[6]  = '{4'd3,  4'd3,  1'b0, 0,   5, S_BRAKE, 50,  S_IDLE};
    tbl[7]  = '{4'd2,  4'd9,  1'b0, 0,   5, S_IDLE,  20,  S_IDLE};
    tbl[8]  = '{4'd1,  4'd0,  1'b0, 16,  5, S_ACCEL, 30,  S_HOLD};
    tbl[9]  = '{4'd1,  4'd0,  1'b1, 8,   0, S_DECEL, 20,  S_HOLD};
    tbl[10] = '{4'd0,  4'd0,  1'b1, 0,   0, S_HOLD,  20,  S_IDLE};

    // Reset wins over en and pedal inputs.
    rst = 1'b1; en = 1'b1; accel_in = 4'd5; brake_in = 4'd0; temp_fault = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_speed", int'(speed_cmd), 0);
      chk("rst_valid", int'(cmd_valid), 0);
      chk("rst_state", int'(ramp_state), S_IDLE);
    end
    rst = 1'b0;
    accel_in = 4'd0;

    // Table-driven pedal scenarios, chained from one settled speed to the next.
    model_speed = 0;
    for (int r = 0; r < 11; r++) begin
      @(negedge clk);
      accel_in = tbl[r].a;
      brake_in = tbl[r].b;
      temp_fault = tbl[r].t;
      push_ramp(model_speed, tbl[r].target, tbl[r].b != 4'd0);
      if (tbl[r].mid == 0) begin
        #1;
      end else begin
        repeat (tbl[r].mid) @(negedge clk);
      end
      chk($sformatf("row%0d_mid_state", r), int'(ramp_state), tbl[r].mid_state);
      repeat (tbl[r].cycles - tbl[r].mid) @(negedge clk);
      chk($sformatf("row%0d_speed", r), int'(speed_cmd), tbl[r].target);
      chk($sformatf("row%0d_state", r), int'(ramp_state), tbl[r].fin_state);
      chk($sformatf("row%0d_pending", r), exp_q.size(), 0);
      model_speed = tbl[r].target;
    end

    // Short pedal glitches must never reach the filtered values.
    @(negedge clk);
    accel_in = 4'd5; brake_in = 4'd0; temp_fault = 1'b0;
    push_ramp(0, 80, 1'b0);
    repeat (100) @(negedge clk);
    chk("glitch_pre_speed", int'(speed_cmd), 80);
    accel_in = 4'd9;
    repeat (2) @(negedge clk);
    accel_in = 4'd5;
    repeat (5) @(negedge clk);
    brake_in = 4'd15;
    repeat (2) @(negedge clk);
    brake_in = 4'd0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 1) chk("glitch_state_mid", int'(ramp_state), S_HOLD);
    end
    chk("glitch_speed", int'(speed_cmd), 80);
    chk("glitch_state", int'(ramp_state), S_HOLD);
    chk("glitch_pending", exp_q.size(), 0);

    // Drop en for one cycle mid-ramp at 40, then re-debounce from zero.
    en = 1'b0;
    exp_q.push_back(0);
    @(negedge clk);
    en = 1'b1;
    chk("en_clear_speed", int'(speed_cmd), 0);
    push_ramp(0, 40, 1'b0);
    hit = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (speed_cmd == 8'd40) begin
        hit = 1;
        break;
      end
    end
    chk("reach40", int'(speed_cmd), 40);
    chk("reach40_hit", hit, 1);
    en = 1'b0;
    exp_q.push_back(0);
    @(negedge clk);
    en = 1'b1;
    chk("en_drop_speed", int'(speed_cmd), 0);
    chk("en_drop_valid", int'(cmd_valid), 1);
    chk("en_drop_state", int'(ramp_state), S_IDLE);
    exp_q.push_back(4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("en_redebounce_speed", int'(speed_cmd), 0);
    end
    @(negedge clk);
    chk("en_first_step", int'(speed_cmd), 4);
    chk("en_first_valid", int'(cmd_valid), 1);

    // Reset mid-ramp at 60 clears everything at once and holds while asserted.
    push_ramp(4, 60, 1'b0);
    hit = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (speed_cmd == 8'd60) begin
        hit = 1;
        break;
      end
    end
    chk("reach60_hit", hit, 1);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("midrst_speed", int'(speed_cmd), 0);
      chk("midrst_valid", int'(cmd_valid), 0);
      chk("midrst_state", int'(ramp_state), S_IDLE);
    end
    rst = 1'b0;
    exp_q.push_back(4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rel_wait_speed", int'(speed_cmd), 0);
    end
    @(negedge clk);
    chk("rel_first_tick", int'(speed_cmd), 4);
    push_ramp(4, 80, 1'b0);
    repeat (90) @(negedge clk);
    chk("rel_final_speed", int'(speed_cmd), 80);
    chk("rel_final_state", int'(ramp_state), S_HOLD);
    chk("rel_pending", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/throttle_ramp_ctrl.md
THROTTLE_RAMP_CTRL -- requirements
Module: throttle_ramp_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 3: consecutive equal samples needed before a pedal value is accepted (range 1..15).
REQ-002 Parameter RAMP_DIV, default 1024: clock cycles per ramp tick (range 2..65535).
REQ-003 Parameter UP_STEP, default 4: speed increment per tick while accelerating.
REQ-004 Parameter DOWN_STEP, default 8: coast-down decrement per tick.
REQ-005 Parameter BRAKE_STEP, default 16: decrement per tick while braking.
REQ-006 clk  in  1  sole clock; all state changes on its rising edge.
REQ-007 rst  in  1  reset; synchronous, active-high.
REQ-008 en  in  1  system enabled (power on from PLC or HMI).
REQ-009 accel_in  in  4  raw accelerator pedal level.
REQ-010 brake_in  in  4  raw brake pedal level.
REQ-011 temp_fault  in  1  overheat flag from the temperature monitor.
REQ-012 speed_cmd  out  8  rate-limited motor speed command, registered.
REQ-013 cmd_valid  out  1  one-cycle pulse marking a new speed_cmd value.
REQ-014 ramp_state  out  3  IDLE=0, ACCEL=1, HOLD=2, DECEL=3, BRAKE=4.

Function
REQ-015 Each pedal has an independent debouncer: held sample, stability counter, filtered value (accel_f, brake_f).
REQ-016 Debouncer: if raw != held sample, the held sample loads raw and the counter clears; otherwise the counter increments, saturating.
REQ-017 The filtered value loads the held sample on the edge where the raw input has been equal on DEB_CYCLES consecutive edges, and holds otherwise; a glitch shorter than DEB_CYCLES edges never reaches the filtered value.
REQ-018 Target = (accel_f - brake_f) * 16 when accel_f > brake_f, else 0; maximum 240, no overflow.
REQ-019 When temp_fault = 1, target is halved (logical right shift by 1) before use.
REQ-020 Tick counter runs 0..RAMP_DIV-1 while en = 1, wraps to 0, and asserts tick for the cycle in which it equals RAMP_DIV-1.
REQ-021 speed_cmd changes only on tick edges.
REQ-022 On a tick with speed_cmd < target: speed_cmd = min(speed_cmd + UP_STEP, target), computed at 9 bits with no wrap.
REQ-023 On a tick with speed_cmd > target: speed_cmd = max(speed_cmd - step, target), with step = BRAKE_STEP if brake_f != 0 else DOWN_STEP; saturates at target, never underflows.
REQ-024 On a tick with speed_cmd == target: no change.
REQ-025 ramp_state is decoded from the current registers:
- IDLE: speed_cmd = 0 and target = 0.
- ACCEL: speed_cmd < target.
- HOLD: speed_cmd = target != 0.
- DECEL: speed_cmd > target and brake_f = 0.
- BRAKE: speed_cmd > target and brake_f != 0.
REQ-026 cmd_valid = 1 exactly in the first cycle speed_cmd shows a changed value, else 0.
REQ-027 When en = 0, on the next edge:
- speed_cmd, tick counter, debouncers and filtered values clear to 0;
- cmd_valid pulses if speed_cmd was nonzero;
- ramp_state reads IDLE.
REQ-028 A target change mid-ramp takes effect at the next tick; the direction reverses with no extra cycle.

Reset
REQ-029 While rst = 1, on each clk edge: speed_cmd = 0, cmd_valid = 0, ramp_state = IDLE, all counters, held samples and filtered values = 0.
REQ-030 rst has priority over en and all other inputs, including when asserted mid-ramp.
REQ-031 The first tick after rst releases occurs RAMP_DIV cycles after release, provided en = 1.

Verification (bench parameters DEB_CYCLES=3, RAMP_DIV=4, defaults otherwise)
REQ-032 en=1, accel_in=5, brake_in=0 held:
- target becomes 80 after 3 edges;
- speed_cmd steps 4,8,...,80, one step every 4 clocks, with a cmd_valid pulse per step;
- ramp_state ACCEL, then HOLD at 80.
REQ-033 From HOLD at 80, brake_in=15:
- after debounce, target = 0, ramp_state BRAKE;
- speed_cmd 64,48,32,16,0 on successive ticks, then IDLE.
REQ-034 accel_in=15 held, temp_fault=1: target = 120; speed_cmd saturates at 120 (30 ticks), ramp_state HOLD.
REQ-035 accel_in=5 settled, accel_in pulsed to 9 for 2 cycles: accel_f stays 5, target stays 80, no cmd_valid outside tick steps.
REQ-036 Ramp at speed_cmd=40, en dropped for 1 cycle:
- next edge gives speed_cmd = 0, cmd_valid = 1, ramp_state IDLE;
- with en back to 1, the ramp restarts from 0 only after re-debounce.
REQ-037 rst asserted mid-ramp at speed_cmd=60: all outputs read 0/IDLE on the next edge and hold while rst = 1.
